tdm_demux: RTL and testbench



---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_slot_ctr.sv | 50 +++++
 rtl/tdm_demux.sv | 187 ++++++++++++++++++
 tb/tb_tdm_demux.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM multiplexer/demultiplexer pair:
// alignment state, default frame geometry and frame counter width.
package tdm_pkg;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

   localparam int unsigned TDM_N_CH_DEF = 4;
   localparam int unsigned TDM_W_DEF    = 8;
   localparam int unsigned TDM_FCNT_W   = 8;

   // Bits needed to hold slot numbers 0..last_slot.
   function automatic int unsigned tdm_slot_w(input int unsigned last_slot);
      return (last_slot < 32'd2) ? 32'd1 : $clog2(last_slot + 32'd1);
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Frame slot counter: clear to 0, load to 1 (channel 0 just taken),
// or advance with wrap from LAST back to 0.
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int unsigned LAST = 3,
   parameter int unsigned SW   = tdm_slot_w(LAST)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          load1_i,
   input  logic          adv_i,
   output logic [SW-1:0] slot_o,
   output logic          at_last_o
);

   localparam logic [SW-1:0] LAST_S = SW'(LAST);
   localparam logic [SW-1:0] ONE_S  = SW'(1);

   logic [SW-1:0] slot_q;
   logic [SW-1:0] slot_d;

   // Next slot value; clear has priority over load, load over advance.
   always_comb begin
      slot_d = slot_q;
      if (clr_i) begin
         slot_d = '0;
      end else if (load1_i) begin
         slot_d = ONE_S;
      end else if (adv_i) begin
         slot_d = (slot_q == LAST_S) ? '0 : slot_q + ONE_S;
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o    = slot_q;
   assign at_last_o = (slot_q == LAST_S);

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: steers each valid word to its channel register and
// tracks frame alignment. Define TDM_DEMUX_PARITY_EN for a per-frame parity slot.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int unsigned N_CH = TDM_N_CH_DEF,
   parameter int unsigned W    = TDM_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [W-1:0]          in_data,
   input  logic                  in_valid,
   input  logic                  in_sync,
   output logic [N_CH*W-1:0]     ch_data,
   output logic [N_CH-1:0]       ch_valid,
   output logic                  frame_done,
   output logic                  sync_err,
`ifdef TDM_DEMUX_PARITY_EN
   output logic                  parity_err,
`endif
   output logic                  locked,
   output logic [TDM_FCNT_W-1:0] frame_cnt
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int unsigned LAST_SLOT = N_CH;
`else
   localparam int unsigned LAST_SLOT = N_CH - 1;
`endif
   localparam int unsigned SLOT_W = tdm_slot_w(LAST_SLOT);
   localparam logic [TDM_FCNT_W-1:0] FCNT_ONE = TDM_FCNT_W'(1);

   tdm_state_e              state_q, state_d;
   logic [N_CH*W-1:0]       ch_data_q, ch_data_d;
   logic [N_CH-1:0]         ch_valid_q, ch_valid_d;
   logic                    done_q, err_q, locked_q, locked_d;
   logic [TDM_FCNT_W-1:0]   cnt_q, cnt_d;
   logic [SLOT_W-1:0]       slot_s;
   logic                    at_last_s;
   logic                    take0_s, wr_en_s, adv_s, clr_s, done_s, err_s;
`ifdef TDM_DEMUX_PARITY_EN
   logic [W-1:0]            par_q, par_d;
   logic                    perr_q, perr_s;

   function automatic logic [W-1:0] par_fold(input logic [W-1:0] acc,
                                             input logic [W-1:0] word);
      return acc ^ word;
   endfunction
`endif

   tdm_slot_ctr #(
      .LAST (LAST_SLOT),
      .SW   (SLOT_W)
   ) u_slot_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr_s),
      .load1_i   (take0_s),
      .adv_i     (adv_s),
      .slot_o    (slot_s),
      .at_last_o (at_last_s)
   );

   // Alignment FSM: decides what the current beat does to the frame.
   always_comb begin
      state_d = state_q;
      take0_s = 1'b0;
      wr_en_s = 1'b0;
      adv_s   = 1'b0;
      clr_s   = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_s  = 1'b0;
`endif
      case (state_q)
         HUNT: begin
            if (in_valid && in_sync) begin
               take0_s = 1'b1;
               state_d = LOCKED;
            end else begin
               state_d = HUNT;
            end
         end
         LOCKED: begin
            if (!in_valid) begin
               state_d = LOCKED;
            end else if (in_sync) begin
               // A sync anywhere but slot 0 abandons the partial frame.
               take0_s = 1'b1;
               err_s   = (slot_s != '0);
            end else if (slot_s == '0) begin
               err_s   = 1'b1;
               clr_s   = 1'b1;
               state_d = HUNT;
`ifdef TDM_DEMUX_PARITY_EN
            end else if (at_last_s) begin
               adv_s = 1'b1;
               if (in_data == par_q) begin
                  done_s = 1'b1;
               end else begin
                  perr_s = 1'b1;
               end
            end else begin
               wr_en_s = 1'b1;
               adv_s   = 1'b1;
            end
`else
            end else begin
               wr_en_s = 1'b1;
               adv_s   = 1'b1;
               done_s  = at_last_s;
            end
`endif
         end
         default: begin
            state_d = HUNT;
            clr_s   = 1'b1;
         end
      endcase
   end

   // Channel steering, strobes and frame counter next values.
   always_comb begin
      ch_data_d  = ch_data_q;
      ch_valid_d = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         if ((take0_s && (k == 0)) || (wr_en_s && (slot_s == SLOT_W'(k)))) begin
            ch_data_d[k*W +: W] = in_data;
            ch_valid_d[k]       = 1'b1;
         end else begin
            ch_valid_d[k]       = 1'b0;
         end
      end
      cnt_d    = done_s ? (cnt_q + FCNT_ONE) : cnt_q;
      locked_d = (state_d == LOCKED);
`ifdef TDM_DEMUX_PARITY_EN
      if (take0_s) begin
         par_d = in_data;
      end else if (wr_en_s) begin
         par_d = par_fold(par_q, in_data);
      end else begin
         par_d = par_q;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         ch_data_q  <= '0;
         ch_valid_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         cnt_q      <= '0;
`ifdef TDM_DEMUX_PARITY_EN
         par_q      <= '0;
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ch_data_q  <= ch_data_d;
         ch_valid_q <= ch_valid_d;
         done_q     <= done_s;
         err_q      <= err_s;
         locked_q   <= locked_d;
         cnt_q      <= cnt_d;
`ifdef TDM_DEMUX_PARITY_EN
         par_q      <= par_d;
         perr_q     <= perr_s;
`endif
      end
   end

   assign ch_data    = ch_data_q;
   assign ch_valid   = ch_valid_q;
   assign frame_done = done_q;
   assign sync_err   = err_q;
   assign locked     = locked_q;
   assign frame_cnt  = cnt_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: hand-derived vector table, corner
// sequences, and randomized beats against a frame-level reference model.
module tb_tdm_demux;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [W-1:0]      in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_sync = 1'b0;
   logic [N_CH*W-1:0] ch_data;
   logic [N_CH-1:0]   ch_valid;
   logic              frame_done, sync_err, locked;
   logic [7:0]        frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
   logic              parity_err;
`endif

   tdm_demux #(.N_CH(N_CH), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sync    (in_sync),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
`ifdef TDM_DEMUX_PARITY_EN
      .parity_err (parity_err),
`endif
      .locked     (locked),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: words seen so far in the current frame, by position.
   logic [W-1:0]    m_ch [N_CH];
   bit              m_locked;
   int              m_pos;
   int              m_cnt;
   logic [W-1:0]    m_par;
   logic [N_CH-1:0] m_valid;
   bit              m_done, m_err, m_perr;

   typedef struct {
      bit          v;
      bit          s;
      logic [7:0]  d;
      logic [3:0]  ev;
      bit          edone;
      bit          eerr;
      bit          elock;
      logic [7:0]  ecnt;
      logic [31:0] edata;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < N_CH; k++) m_ch[k] = '0;
      m_locked = 0; m_pos = 0; m_cnt = 0; m_par = '0;
      m_valid = '0; m_done = 0; m_err = 0; m_perr = 0;
   endfunction

   function automatic void model_take0(input logic [W-1:0] d);
      m_ch[0] = d; m_valid[0] = 1'b1; m_pos = 1; m_par = d; m_locked = 1;
   endfunction

   function automatic void model_step(input bit v, input bit s, input logic [W-1:0] d);
      m_valid = '0; m_done = 0; m_err = 0; m_perr = 0;
      if (!v) return;
      if (!m_locked) begin
         if (s) model_take0(d);
      end else if (s) begin
         m_err = (m_pos != 0);
         model_take0(d);
      end else if (m_pos == 0) begin
         m_err = 1; m_locked = 0;
      end else if (m_pos == N_CH) begin
         if (d == m_par) begin
            m_done = 1; m_cnt = (m_cnt + 1) % 256;
         end else begin
            m_perr = 1;
         end
         m_pos = 0;
      end else begin
         m_ch[m_pos] = d; m_valid[m_pos] = 1'b1; m_par = m_par ^ d;
         m_pos++;
`ifndef TDM_DEMUX_PARITY_EN
         if (m_pos == N_CH) begin
            m_pos = 0; m_done = 1; m_cnt = (m_cnt + 1) % 256;
         end
`endif
      end
   endfunction

   function automatic logic [N_CH*W-1:0] m_flat();
      logic [N_CH*W-1:0] r;
      for (int k = 0; k < N_CH; k++) r[k*W +: W] = m_ch[k];
      return r;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " ch_data"},    64'(ch_data),    64'(m_flat()));
      chk({tag, " ch_valid"},   64'(ch_valid),   64'(m_valid));
      chk({tag, " frame_done"}, 64'(frame_done), 64'(m_done));
      chk({tag, " sync_err"},   64'(sync_err),   64'(m_err));
      chk({tag, " locked"},     64'(locked),     64'(m_locked));
      chk({tag, " frame_cnt"},  64'(frame_cnt),  64'(m_cnt));
`ifdef TDM_DEMUX_PARITY_EN
      chk({tag, " parity_err"}, 64'(parity_err), 64'(m_perr));
`endif
   endtask

   task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
      @(negedge clk);
      in_valid = v; in_sync = s; in_data = d;
      model_step(v, s, d);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input bit v, input bit s, input logic [W-1:0] d);
      drive(v, s, d);
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic void add(input bit v, input bit s, input logic [7:0] d,
                               input logic [3:0] ev, input bit edone, input bit eerr,
                               input bit elock, input logic [7:0] ecnt, input logic [31:0] edata);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.ev = ev; t.edone = edone; t.eerr = eerr;
      t.elock = elock; t.ecnt = ecnt; t.edata = edata;
      vq.push_back(t);
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("por ch_data", 64'(ch_data), 64'h0);
      chk("por locked", 64'(locked), 64'h0);
      chk("por frame_cnt", 64'(frame_cnt), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hand-derived vectors.
      add(1, 0, 8'h55, 4'b0000, 0, 0, 0, 8'd0, 32'h00000000);
      add(1, 0, 8'h66, 4'b0000, 0, 0, 0, 8'd0, 32'h00000000);
      add(1, 1, 8'h11, 4'b0001, 0, 0, 1, 8'd0, 32'h00000011);
      add(1, 0, 8'h22, 4'b0010, 0, 0, 1, 8'd0, 32'h00002211);
      add(0, 1, 8'h99, 4'b0000, 0, 0, 1, 8'd0, 32'h00002211);
      add(1, 0, 8'h33, 4'b0100, 0, 0, 1, 8'd0, 32'h00332211);
`ifdef TDM_DEMUX_PARITY_EN
      add(1, 0, 8'h44, 4'b1000, 0, 0, 1, 8'd0, 32'h44332211);
      add(1, 0, 8'h44, 4'b0000, 1, 0, 1, 8'd1, 32'h44332211);
`else
      add(1, 0, 8'h44, 4'b1000, 1, 0, 1, 8'd1, 32'h44332211);
`endif
      add(1, 1, 8'h01, 4'b0001, 0, 0, 1, 8'd1, 32'h44332201);
      add(1, 0, 8'h02, 4'b0010, 0, 0, 1, 8'd1, 32'h44330201);
      add(1, 1, 8'hAA, 4'b0001, 0, 1, 1, 8'd1, 32'h443302AA);
      add(1, 0, 8'hBB, 4'b0010, 0, 0, 1, 8'd1, 32'h4433BBAA);
      add(1, 0, 8'hCC, 4'b0100, 0, 0, 1, 8'd1, 32'h44CCBBAA);
`ifdef TDM_DEMUX_PARITY_EN
      add(1, 0, 8'hDD, 4'b1000, 0, 0, 1, 8'd1, 32'hDDCCBBAA);
      add(1, 0, 8'h00, 4'b0000, 1, 0, 1, 8'd2, 32'hDDCCBBAA);
`else
      add(1, 0, 8'hDD, 4'b1000, 1, 0, 1, 8'd2, 32'hDDCCBBAA);
`endif
      add(1, 0, 8'hEE, 4'b0000, 0, 1, 0, 8'd2, 32'hDDCCBBAA);
      add(1, 1, 8'h12, 4'b0001, 0, 0, 1, 8'd2, 32'hDDCCBB12);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].v, vq[i].s, vq[i].d);
         chk($sformatf("vec%0d ch_valid", i),   64'(ch_valid),   64'(vq[i].ev));
         chk($sformatf("vec%0d frame_done", i), 64'(frame_done), 64'(vq[i].edone));
         chk($sformatf("vec%0d sync_err", i),   64'(sync_err),   64'(vq[i].eerr));
         chk($sformatf("vec%0d locked", i),     64'(locked),     64'(vq[i].elock));
         chk($sformatf("vec%0d frame_cnt", i),  64'(frame_cnt),  64'(vq[i].ecnt));
         chk($sformatf("vec%0d ch_data", i),    64'(ch_data),    64'(vq[i].edata));
      end

      // Reset in the middle of a frame.
      step("pre_rst", 1, 0, 8'h34);
      do_reset();
      chk("mid_rst ch_data", 64'(ch_data), 64'h0);
      chk("mid_rst locked", 64'(locked), 64'h0);
      step("post_rst_hunt", 1, 0, 8'h77);

      // 256 complete frames with a 3-cycle gap mid-frame: counter wraps.
      for (int f = 0; f < 256; f++) begin
         step("wrap", 1, 1, 8'($urandom));
         for (int k = 1; k < N_CH; k++) begin
            if (k == 2) begin
               for (int g = 0; g < 3; g++) step("gap", 0, 0, 8'($urandom));
            end
            step("wrap", 1, 0, 8'($urandom));
         end
`ifdef TDM_DEMUX_PARITY_EN
         step("wrap_par", 1, 0, m_par);
`endif
      end
      chk("wrap frame_cnt", 64'(frame_cnt), 64'h0);
      chk("wrap locked", 64'(locked), 64'h1);

`ifdef TDM_DEMUX_PARITY_EN
      do_reset();
      step("par", 1, 1, 8'h01);
      step("par", 1, 0, 8'h02);
      step("par", 1, 0, 8'h04);
      step("par", 1, 0, 8'h08);
      step("par_ok", 1, 0, 8'h0F);
      chk("par_ok frame_done", 64'(frame_done), 64'h1);
      chk("par_ok parity_err", 64'(parity_err), 64'h0);
      step("par", 1, 1, 8'h01);
      step("par", 1, 0, 8'h02);
      step("par", 1, 0, 8'h04);
      step("par", 1, 0, 8'h08);
      step("par_bad", 1, 0, 8'h0E);
      chk("par_bad parity_err", 64'(parity_err), 64'h1);
      chk("par_bad frame_done", 64'(frame_done), 64'h0);
      chk("par_bad frame_cnt", 64'(frame_cnt), 64'h1);
      chk("par_bad locked", 64'(locked), 64'h1);
`endif

      // Randomized beats against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit           v, s;
         logic [W-1:0] d;
         v = ($urandom_range(0, 3) != 0);
         if (!m_locked)        s = ($urandom_range(0, 2) == 0);
         else if (m_pos == 0)  s = ($urandom_range(0, 9) != 0);
         else                  s = ($urandom_range(0, 11) == 0);
         d = W'($urandom);
`ifdef TDM_DEMUX_PARITY_EN
         if (m_pos == N_CH && $urandom_range(0, 3) != 0) d = m_par;
`endif
         step("rand", v, s, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
